// File: rtl/cu_pkg.sv
// Shared constants and types for the command link. The command receiver
// decodes packets using these same definitions.
package cu_pkg;

  // Header byte per packet type; data bytes never reach 0x80 and up
  localparam logic [7:0] HDR_START  = 8'h80;
  localparam logic [7:0] HDR_STOP   = 8'hA0;
  localparam logic [7:0] HDR_STATUS = 8'hC0;

  // Upper nibble of every data byte, keeps data in 0x30-0x3F
  localparam logic [3:0] NIB_PREFIX = 4'h3;

  // Data nibbles per packet (24-bit payload)
  localparam int PKT_NIBBLES = 6;

  typedef enum logic [1:0] {
    PKT_START   = 2'd0,
    PKT_STOP    = 2'd1,
    PKT_STATUS  = 2'd2,
    PKT_ILLEGAL = 2'd3
  } pkt_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT,
    ST_FIN
  } cu_state_e;

  function automatic logic [7:0] hdr_byte(pkt_type_e t);
    case (t)
      PKT_STOP:   return HDR_STOP;
      PKT_STATUS: return HDR_STATUS;
      default:    return HDR_START;
    endcase
  endfunction

  // Byte idx of a packet: 0 is the header, 1..6 carry nibbles MSB first
  function automatic logic [7:0] pkt_byte(pkt_type_e t, logic [23:0] d, logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd1:    b = {NIB_PREFIX, d[23:20]};
      3'd2:    b = {NIB_PREFIX, d[19:16]};
      3'd3:    b = {NIB_PREFIX, d[15:12]};
      3'd4:    b = {NIB_PREFIX, d[11:8]};
      3'd5:    b = {NIB_PREFIX, d[7:4]};
      3'd6:    b = {NIB_PREFIX, d[3:0]};
      default: b = hdr_byte(t);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cu_tx_if.sv
// Request/status handshake between the control FSM and the command transmitter.
interface cu_tx_if;
  logic        send_req;
  logic [1:0]  send_type;
  logic [23:0] send_data;
  logic        busy;
  logic        pkt_done;

  modport master (
    output send_req, send_type, send_data,
    input  busy, pkt_done
  );

  modport slave (
    input  send_req, send_type, send_data,
    output busy, pkt_done
  );
endinterface

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, stop bit.
// Each bit lasts crystal/baud clocks.
module uart_tx #(
  parameter int crystal = 16384000,
  parameter int baud    = 57600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] din_byte,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BIT_CLKS = crystal / baud;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CLKS - 1);

  logic [9:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             busy_q, busy_d;
  logic             bit_end;

  // Frame sequencing: load a frame when idle, otherwise step bit by bit
  always_comb begin
    shreg_d    = shreg_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    busy_d     = busy_q;
    bit_end    = busy_q && (baud_cnt_q == BIT_LAST);
    if (!busy_q) begin
      if (tx_start) begin
        shreg_d    = {1'b1, din_byte, 1'b0};
        busy_d     = 1'b1;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    end else if (bit_end) begin
      baud_cnt_d = '0;
      shreg_d    = {1'b1, shreg_q[9:1]};
      if (bit_cnt_q == 4'd9) begin
        busy_d    = 1'b0;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else begin
      baud_cnt_d = baud_cnt_q + CNT_W'(1);
    end
  end

  // State registers; an all-ones shifter holds the line idle high
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg_q    <= '1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign tx      = shreg_q[0];
  assign tx_busy = busy_q;
  assign tx_done = bit_end && (bit_cnt_q == 4'd9);

endmodule

// File: rtl/cu_tx.sv
// Command transmitter: serialises a 24-bit word as a 7-byte packet
// (header + 6 nibble bytes, MSB nibble first) over one UART line.
module cu_tx
  import cu_pkg::*;
#(
  parameter int crystal = 16384000,
  parameter int baud    = 57600
) (
  input  logic   clk,
  input  logic   reset,
  cu_tx_if.slave bus,
  output logic   tx,
  output logic   tx_done1
);

  cu_state_e   state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  pkt_type_e   type_q, type_d;
  logic [23:0] data_q, data_d;
  logic        tx_done1_q, tx_done1_d;

  logic        tx_start;
  logic [7:0]  din_byte;
  logic        u_busy;
  logic        u_done;
  logic        busy;
  logic        pkt_done;

  // Packet sequencing: capture request, then load/send each byte in turn
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    type_d     = type_q;
    data_d     = data_q;
    tx_start   = 1'b0;
    pkt_done   = 1'b0;
    din_byte   = pkt_byte(type_q, data_q, cnt_q);
    tx_done1_d = tx_done1_q ^ u_done;
    busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
    case (state_q)
      ST_IDLE: begin
        if (bus.send_req && (pkt_type_e'(bus.send_type) != PKT_ILLEGAL)) begin
          type_d  = pkt_type_e'(bus.send_type);
          data_d  = bus.send_data;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!u_busy) begin
          tx_start = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (u_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (cnt_q == 3'(PKT_NIBBLES)) begin
          state_d = ST_FIN;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        pkt_done = 1'b1;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any packet in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      type_q     <= PKT_START;
      data_q     <= '0;
      tx_done1_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      type_q     <= type_d;
      data_q     <= data_d;
      tx_done1_q <= tx_done1_d;
    end
  end

  uart_tx #(
    .crystal(crystal),
    .baud   (baud)
  ) u_uart (
    .clk     (clk),
    .reset   (reset),
    .tx_start(tx_start),
    .din_byte(din_byte),
    .tx      (tx),
    .tx_busy (u_busy),
    .tx_done (u_done)
  );

  assign bus.busy     = busy;
  assign bus.pkt_done = pkt_done;
  assign tx_done1     = tx_done1_q;

endmodule
